// File: rtl/loac_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : loac_mem_pkg
// Brief   : Shared types and helpers for the LED lookup-table write side.
// Revision: 1.0 - initial release
// ============================================================================
package loac_mem_pkg;

    localparam int LUTW_DATA_W = 4;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_WRITE = 2'd2,
        S_ACK   = 2'd3
    } lutw_state_t;

    // Default table contents: 3*(idx+1), truncated to the word width.
    function automatic logic [LUTW_DATA_W-1:0] init_word(input int unsigned idx);
        int unsigned w_full;
        w_full = 3 * (idx + 1);
        return w_full[LUTW_DATA_W-1:0];
    endfunction

endpackage : loac_mem_pkg
`default_nettype wire

// File: rtl/lut_writer_edge_rise.sv
`default_nettype none
// ============================================================================
// Module  : edge_rise
// Brief   : Single-flop rising-edge detector, shared with the button inputs.
// Revision: 1.0 - initial release
// ============================================================================
module edge_rise (
    input  logic clk_2,
    input  logic reset,
    input  logic d,
    output logic q_rise
);

    logic r_q;

    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_q <= 1'b0;
        end else begin
            r_q <= d;
        end
    end

    assign q_rise = d & ~r_q;

endmodule : edge_rise
`default_nettype wire

// File: rtl/lut_writer.sv
`default_nettype none
// ============================================================================
// Module  : lut_writer
// Brief   : Loads the default 4x4 LED table after reset, then serves single
//           req/done user writes; combinational read port for the LED logic.
// Revision: 1.0 - initial release
// ============================================================================
module lut_writer
    import loac_mem_pkg::*;
#(
    parameter int NBITS_DATA = 4,
    parameter int NBITS_ADDR = 2,
    parameter int NBITS_CNT  = 8
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic [NBITS_ADDR-1:0] wr_addr,
    input  logic [NBITS_DATA-1:0] wr_data,
    input  logic [NBITS_ADDR-1:0] rd_addr,
    output logic [NBITS_DATA-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [NBITS_CNT-1:0]  wr_count
);

    localparam int NWORDS = 2 ** NBITS_ADDR;

    lutw_state_t           r_state;
    lutw_state_t           w_state_next;
    logic                  w_rise;
    logic [NBITS_ADDR-1:0] r_init_ptr;
    logic [NBITS_ADDR-1:0] r_addr_q;
    logic [NBITS_DATA-1:0] r_data_q;
    logic [NBITS_CNT-1:0]  r_wr_count;
    logic [NBITS_DATA-1:0] r_mem [NWORDS];

    edge_rise u_edge_rise (
        .clk_2  (clk_2),
        .reset  (reset),
        .d      (wr_req),
        .q_rise (w_rise)
    );

    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_INIT: begin
                if (r_init_ptr == NBITS_ADDR'(NWORDS - 1)) begin
                    w_state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_rise) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_next = S_ACK;
            end
            S_ACK: begin
                // Held request keeps done asserted until the requester lets go.
                if (!wr_req) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            for (int i = 0; i < NWORDS; i++) begin
                r_mem[i] <= '0;
            end
            r_init_ptr <= '0;
            r_addr_q   <= '0;
            r_data_q   <= '0;
            r_wr_count <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_mem[r_init_ptr] <= NBITS_DATA'(init_word(32'(r_init_ptr)));
                    r_init_ptr        <= r_init_ptr + 1'b1;
                end
                S_IDLE: begin
                    if (w_rise) begin
                        r_addr_q <= wr_addr;
                        r_data_q <= wr_data;
                    end
                end
                S_WRITE: begin
                    r_mem[r_addr_q] <= r_data_q;
                    r_wr_count      <= r_wr_count + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Reset overrides the state decode so the reset cycle itself reads busy.
    assign rd_data  = r_mem[rd_addr];
    assign busy     = reset | (r_state != S_IDLE);
    assign done     = ~reset & (r_state == S_ACK);
    assign wr_count = r_wr_count;

endmodule : lut_writer
`default_nettype wire
